// File: rtl/wm8731_pkg.sv
// Shared constants, state encoding and slot-bit helper for the WM8731 I2S audio path.
package wm8731_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int SLOT_BCLKS  = 32;
    localparam int FRAME_BCLKS = 64;
    localparam int SLOT_W      = $clog2(SLOT_BCLKS);
    localparam int BC_W        = $clog2(FRAME_BCLKS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_e;

    // Serial bit for frame position pos: slot bit k=1..16 carries sample bit 16-k,
    // slot bits 0 and 17..31 are zero; pos MSB selects the left/right half of the word.
    function automatic logic slot_bit(input logic [2*SAMPLE_W-1:0] word,
                                      input logic [BC_W-1:0] pos);
        logic [SLOT_W-1:0] k;
        logic [SLOT_W-1:0] idx;
        k = pos[SLOT_W-1:0];
        if (k == '0 || k > SLOT_W'(SAMPLE_W)) begin
            return 1'b0;
        end
        idx = pos[BC_W-1] ? (SLOT_W'(SAMPLE_W) - k) : (SLOT_W'(0) - k);
        return word[idx];
    endfunction

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Read side of the first-word fall-through playback FIFO.
interface i2s_dac_tx_if #(
    parameter int B = 32
);
    logic         fifo_empty;
    logic [B-1:0] fifo_data;
    logic         fifo_rd;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd
    );
endinterface

// File: rtl/i2s_clk_gen.sv
// BCLK divider and 64-bit frame position counter; bc advances on every bclk fall.
module i2s_clk_gen
    import wm8731_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            bclk,
    output logic [BC_W-1:0] bc,
    output logic            fall_evt,
    output logic            frame_end
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             tick;

    assign tick      = run && (div == DIV_LAST);
    assign fall_evt  = tick && bclk;
    assign frame_end = fall_evt && (bc == BC_W'(FRAME_BCLKS - 1));

    // Holding everything cleared while stopped makes the first rise land BCLK_DIV cycles after start.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            div  <= '0;
            bclk <= 1'b0;
            bc   <= '0;
        end else if (tick) begin
            div  <= '0;
            bclk <= ~bclk;
            if (bclk) begin
                bc <= bc + BC_W'(1);
            end
        end else begin
            div <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// Master-mode I2S transmitter: one FIFO pop per frame, MSB-first left/right serialization.
//   state | meaning
//   IDLE  | outputs parked low, clock generator cleared
//   RUN   | frames streaming; enable only looked at on the frame boundary
module i2s_dac_tx
    import wm8731_pkg::*;
#(
    parameter int B        = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    i2s_dac_tx_if.master fifo,
    output logic         bclk,
    output logic         daclrc,
    output logic         dacdat,
    output logic         underrun,
    output logic         busy
);

    tx_state_e       state;
    logic [B-1:0]    shift_reg;
    logic            fifo_rd;
    logic            run;
    logic            fetch;
    logic            fall_evt;
    logic            frame_end;
    logic [BC_W-1:0] bc;
    logic [BC_W-1:0] bc_next;

    assign run          = (state == RUN);
    assign bc_next      = bc + BC_W'(1);
    assign fetch        = enable && ((state == IDLE) || frame_end);
    assign fifo.fifo_rd = fifo_rd;

    i2s_clk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .bclk      (bclk),
        .bc        (bc),
        .fall_evt  (fall_evt),
        .frame_end (frame_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            fifo_rd   <= 1'b0;
            underrun  <= 1'b0;
            busy      <= 1'b0;
            daclrc    <= 1'b0;
            dacdat    <= 1'b0;
        end else begin
            fifo_rd  <= 1'b0;
            underrun <= 1'b0;
            // The head word is captured on the pop edge, so the FIFO advancing afterwards is harmless.
            if (fetch) begin
                shift_reg <= fifo.fifo_empty ? '0 : fifo.fifo_data;
                fifo_rd   <= !fifo.fifo_empty;
                underrun  <= fifo.fifo_empty;
            end
            case (state)
                IDLE: begin
                    busy   <= 1'b0;
                    daclrc <= 1'b0;
                    dacdat <= 1'b0;
                    if (enable) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (frame_end && !enable) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        daclrc <= 1'b0;
                        dacdat <= 1'b0;
                    end else if (fall_evt) begin
                        daclrc <= bc_next[BC_W-1];
                        dacdat <= slot_bit(shift_reg, bc_next);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: a BCLK_DIV=2 instance for most scenarios, a BCLK_DIV=1 instance for the corner.
`timescale 1ns/1ps
module tb_i2s_dac_tx;

    localparam int ACT_NONE = 0;
    localparam int ACT_DROP = 1;
    localparam int ACT_PUSH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int     n_assert = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    always @(posedge clk) cyc++;

    logic rst2, en2, bclk2, lrc2, dat2, und2, busy2;
    logic rst1, en1, bclk1, lrc1, dat1, und1, busy1;

    i2s_dac_tx_if #(.B(32)) f2 ();
    i2s_dac_tx_if #(.B(32)) f1 ();

    i2s_dac_tx #(.B(32), .BCLK_DIV(2)) dut2 (
        .clk(clk), .reset(rst2), .enable(en2), .fifo(f2),
        .bclk(bclk2), .daclrc(lrc2), .dacdat(dat2), .underrun(und2), .busy(busy2)
    );

    i2s_dac_tx #(.B(32), .BCLK_DIV(1)) dut1 (
        .clk(clk), .reset(rst1), .enable(en1), .fifo(f1),
        .bclk(bclk1), .daclrc(lrc1), .dacdat(dat1), .underrun(und1), .busy(busy1)
    );

    // FIFO models: each is the sole writer of its queue; pushes arrive via a sequence handshake.
    logic [31:0] q2[$];
    logic [31:0] q1[$];
    logic [31:0] push_word2 = '0, push_word1 = '0;
    int push_seq2 = 0, push_seq1 = 0, seen2 = 0, seen1 = 0;
    int rd_cnt2 = 0, und_cnt2 = 0, busy_cyc2 = 0;
    int rd_cnt1 = 0, und_cnt1 = 0, busy_cyc1 = 0;
    longint rd_at2[$];

    always @(negedge clk) begin
        if (f2.fifo_rd === 1'b1) begin
            rd_cnt2++;
            rd_at2.push_back(cyc);
            if (q2.size() > 0) void'(q2.pop_front());
        end
        if (push_seq2 != seen2) begin
            q2.push_back(push_word2);
            seen2 = push_seq2;
        end
        if (und2 === 1'b1) und_cnt2++;
        if (busy2 === 1'b1) busy_cyc2++;
        f2.fifo_empty = (q2.size() == 0);
        f2.fifo_data  = (q2.size() > 0) ? q2[0] : 32'h0;
    end

    always @(negedge clk) begin
        if (f1.fifo_rd === 1'b1) begin
            rd_cnt1++;
            if (q1.size() > 0) void'(q1.pop_front());
        end
        if (push_seq1 != seen1) begin
            q1.push_back(push_word1);
            seen1 = push_seq1;
        end
        if (und1 === 1'b1) und_cnt1++;
        if (busy1 === 1'b1) busy_cyc1++;
        f1.fifo_empty = (q1.size() == 0);
        f1.fifo_data  = (q1.size() > 0) ? q1[0] : 32'h0;
    end

    logic sel = 1'b0;
    logic c_bclk, c_lrc, c_dat;
    assign c_bclk = sel ? bclk1 : bclk2;
    assign c_lrc  = sel ? lrc1  : lrc2;
    assign c_dat  = sel ? dat1  : dat2;

    logic [63:0] dv, lv;
    int first_lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        if (sel) begin
            push_word1 = w;
            push_seq1++;
        end else begin
            push_word2 = w;
            push_seq2++;
        end
    endtask

    task automatic do_action(input int act, input logic [31:0] w);
        if (act == ACT_DROP) begin
            if (sel) en1 = 1'b0; else en2 = 1'b0;
        end else if (act == ACT_PUSH) begin
            push(w);
        end
    endtask

    // Records dacdat/daclrc at each bclk rise; rise r lands in bit r-1 of dv/lv.
    task automatic capture(input int nrises, input int act_at, input int act, input logic [31:0] w);
        logic prev;
        int got, since;
        prev = c_bclk;
        got = 0;
        since = 0;
        first_lat = -1;
        dv = '0;
        lv = '0;
        while (got < nrises && since < nrises * 8 + 32) begin
            @(negedge clk);
            since++;
            if (c_bclk === 1'b1 && prev === 1'b0) begin
                dv[got] = c_dat;
                lv[got] = c_lrc;
                got++;
                if (got == 1) first_lat = since;
                if (got == act_at) do_action(act, w);
            end
            prev = c_bclk;
        end
        check("rise_count", 64'(got), 64'(nrises));
    endtask

    task automatic check_frame(input string tag, input logic [31:0] w);
        logic [15:0] l, r;
        logic [63:0] rest;
        for (int i = 0; i < 16; i++) begin
            l[15-i] = dv[1+i];
            r[15-i] = dv[33+i];
        end
        rest = dv;
        rest[16:1]  = '0;
        rest[48:33] = '0;
        check({tag, "_left"},  64'(l), 64'(w[31:16]));
        check({tag, "_right"}, 64'(r), 64'(w[15:0]));
        check({tag, "_zero_bits"}, rest, 64'h0);
        check({tag, "_lrc"}, lv, 64'hFFFF_FFFF_0000_0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words[4];
        int base_rd, base_und, base_at;
        words[0] = 32'h1111_2222;
        words[1] = 32'h3333_4444;
        words[2] = 32'h5555_6666;
        words[3] = 32'h7777_8888;

        rst2 = 1'b1; en2 = 1'b1;
        rst1 = 1'b1; en1 = 1'b0;

        // Reset held with enable high; word preloaded for the single-word frame that follows.
        @(negedge clk);
        push(32'hA5A5_3C3C);
        repeat (5) @(negedge clk);
        check("reset_outs", 64'({bclk2, lrc2, dat2, f2.fifo_rd, und2, busy2}), 64'h0);
        check("reset_outs_div1", 64'({bclk1, lrc1, dat1, f1.fifo_rd, und1, busy1}), 64'h0);
        rst2 = 1'b0;
        @(negedge clk);
        check("start_busy_bclk_rd_und", 64'({busy2, bclk2, f2.fifo_rd, und2}), 64'b1010);
        capture(64, 10, ACT_DROP, 32'h0);
        check("first_rise_latency", 64'(first_lat), 64'd2);
        check_frame("single", 32'hA5A5_3C3C);
        @(negedge clk);
        check("stop_pending_busy", 64'(busy2), 64'd1);
        @(negedge clk);
        check("stop_idle_outs", 64'({busy2, bclk2, lrc2, dat2}), 64'h0);
        check("single_frame_cycles", 64'(busy_cyc2), 64'd256);
        repeat (10) @(negedge clk);
        check("single_pop_count", 64'(rd_cnt2), 64'd1);
        check("single_underrun_count", 64'(und_cnt2), 64'd0);

        // Underrun frame, then a word pushed mid-frame is only popped at the boundary.
        en2 = 1'b1;
        @(negedge clk);
        check("underrun_start", 64'({busy2, f2.fifo_rd, und2}), 64'b101);
        capture(64, 20, ACT_PUSH, 32'hFFFF_0001);
        check("underrun_data_zero", dv, 64'h0);
        check("underrun_lrc", lv, 64'hFFFF_FFFF_0000_0000);
        check("underrun_no_early_pop", 64'(rd_cnt2), 64'd1);
        check("underrun_count", 64'(und_cnt2), 64'd1);
        capture(64, 10, ACT_DROP, 32'h0);
        check_frame("refill", 32'hFFFF_0001);
        repeat (10) @(negedge clk);
        check("refill_pop_count", 64'(rd_cnt2), 64'd2);
        check("refill_underrun_count", 64'(und_cnt2), 64'd1);

        // Back-to-back frames from four queued words.
        for (int i = 0; i < 4; i++) begin
            push(words[i]);
            repeat (2) @(negedge clk);
        end
        base_rd  = rd_cnt2;
        base_und = und_cnt2;
        base_at  = rd_at2.size();
        en2 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            capture(64, (i == 3) ? 10 : 0, (i == 3) ? ACT_DROP : ACT_NONE, 32'h0);
            check_frame($sformatf("b2b%0d", i), words[i]);
        end
        repeat (10) @(negedge clk);
        check("b2b_pop_count", 64'(rd_cnt2 - base_rd), 64'd4);
        check("b2b_underrun_count", 64'(und_cnt2 - base_und), 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (rd_at2.size() >= base_at + i + 2)
                check($sformatf("b2b_spacing%0d", i),
                      64'(rd_at2[base_at+i+1] - rd_at2[base_at+i]), 64'd256);
            else
                check($sformatf("b2b_spacing%0d", i), 64'(rd_at2.size()), 64'(base_at + i + 2));
        end

        // Reset asserted late in the left... right slot (around bc=40).
        push(32'h1234_5678);
        repeat (2) @(negedge clk);
        base_rd  = rd_cnt2;
        base_und = und_cnt2;
        en2 = 1'b1;
        @(negedge clk);
        capture(40, 0, ACT_NONE, 32'h0);
        begin
            logic [15:0] l;
            for (int i = 0; i < 16; i++) l[15-i] = dv[1+i];
            check("midreset_left", 64'(l), 64'h1234);
        end
        rst2 = 1'b1;
        @(negedge clk);
        check("midreset_outs", 64'({bclk2, lrc2, dat2, f2.fifo_rd, und2, busy2}), 64'h0);
        en2 = 1'b0;
        repeat (3) @(negedge clk);
        rst2 = 1'b0;
        repeat (5) @(negedge clk);
        check("midreset_idle_outs", 64'({bclk2, lrc2, dat2, f2.fifo_rd, und2, busy2}), 64'h0);
        check("midreset_pop_count", 64'(rd_cnt2 - base_rd), 64'd1);
        check("midreset_underrun_count", 64'(und_cnt2 - base_und), 64'd0);

        // BCLK_DIV=1 corner.
        sel = 1'b1;
        push(32'hA5A5_3C3C);
        repeat (2) @(negedge clk);
        en1 = 1'b1;
        rst1 = 1'b0;
        @(negedge clk);
        check("div1_start", 64'({busy1, bclk1, f1.fifo_rd, und1}), 64'b1010);
        capture(64, 10, ACT_DROP, 32'h0);
        check("div1_first_rise_latency", 64'(first_lat), 64'd1);
        check_frame("div1", 32'hA5A5_3C3C);
        @(negedge clk);
        check("div1_stop_outs", 64'({busy1, bclk1, lrc1, dat1}), 64'h0);
        check("div1_frame_cycles", 64'(busy_cyc1), 64'd128);
        repeat (5) @(negedge clk);
        check("div1_pop_count", 64'(rd_cnt1), 64'd1);
        check("div1_underrun_count", 64'(und_cnt1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
